// File: rtl/user_code_loader_pkg.sv
// Shared definitions for the byte-stream user-code loader.
// Frame parser state encoding and the default frame start marker.
package user_code_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StWr,
    StCsum
  } ld_state_e;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

endpackage

// File: rtl/user_code_loader_csum.sv
// XOR checksum accumulator for the loader frame.
// Clear takes priority over enable; the result is the running XOR of enabled bytes.
module user_code_loader_csum (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] csum_o
);

  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr_i) begin
      csum_d = 8'h00;
    end else if (en_i) begin
      csum_d = csum_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/user_code_loader.sv
// Byte-stream program loader: parses SYNC, N, N x {HI, LO}, CSUM frames and writes
// 16-bit instruction words into code memory, holding the CPU while loading or after an error.
module user_code_loader
  import user_code_loader_pkg::*;
#(
  parameter int unsigned Depth    = 32,
  parameter int unsigned AddrW    = 5,
  parameter logic [7:0]  SyncByte = SyncByteDefault
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [15:0]      mem_data_o,
  output logic             cpu_hold_o,
  output logic             load_done_o,
  output logic             load_err_o
);

  // One extra bit so a word count of exactly Depth is representable.
  localparam int unsigned CntW = AddrW + 1;

  ld_state_e        state_q, state_d;
  logic [CntW-1:0]  n_q, n_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [7:0]       hi_q, hi_d;
  logic             mem_we_q, mem_we_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]      mem_data_q, mem_data_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       accept;
  logic       csum_clr, csum_en;
  logic [7:0] csum_val;

  assign in_ready_o = (state_q != StWr);
  assign accept     = in_valid_i && in_ready_o;

  user_code_loader_csum u_csum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (csum_clr),
    .en_i    (csum_en),
    .data_i  (in_data_i),
    .csum_o  (csum_val)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    csum_clr   = 1'b0;
    csum_en    = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept && (in_data_i == SyncByte)) begin
          state_d  = StLen;
          done_d   = 1'b0;
          err_d    = 1'b0;
          hold_d   = 1'b1;
          csum_clr = 1'b1;
        end
      end
      StLen: begin
        if (accept) begin
          if ((in_data_i == 8'd0) || (32'(in_data_i) > Depth)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            n_d     = CntW'(in_data_i);
            csum_en = 1'b1;
            addr_d  = '0;
            state_d = StHi;
          end
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = in_data_i;
          csum_en = 1'b1;
          state_d = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          mem_data_d = {hi_q, in_data_i};
          mem_addr_d = addr_q;
          mem_we_d   = 1'b1;
          csum_en    = 1'b1;
          state_d    = StWr;
        end
      end
      StWr: begin
        // Last word leaves addr at N-1, so a full-depth frame never wraps the counter.
        if (({1'b0, addr_q} + CntW'(1)) == n_q) begin
          state_d = StCsum;
        end else begin
          addr_d  = addr_q + AddrW'(1);
          state_d = StHi;
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = StIdle;
          if (in_data_i == csum_val) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      n_q        <= '0;
      addr_q     <= '0;
      hi_q       <= 8'h00;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 16'h0000;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign cpu_hold_o  = hold_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

endmodule

// File: tb/tb_user_code_loader.sv
// Directed bench for user_code_loader: frame-level model predicts writes and flags,
// one compare process checks every write and the handshake each cycle.
module tb_user_code_loader;

  localparam int Depth = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  user_code_loader dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .cpu_hold_o  (cpu_hold),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [4:0]  obs_addr[$];
  logic [15:0] obs_data[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned notready_cnt = 0;
  bit          gaps = 0;
  bit          exp_done, exp_err, exp_hold;
  logic [15:0] words[0:Depth-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: a write must match the oldest predicted write and land exactly one cycle
  // after its LO byte; in_ready must be low in exactly the write cycles.
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_vs_we", 32'(in_ready), 32'(!mem_we));
      check("done_err_exclusive", 32'(load_done & load_err), 32'd0);
      if (!in_ready) notready_cnt++;
      if (mem_we) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr,
                   mem_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_cycle", cyc, e.due);
          check("write_addr", 32'(mem_addr), 32'(e.addr));
          check("write_data", 32'(mem_data), 32'(e.data));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_lo, input logic [4:0] a,
                           input logic [15:0] d);
    int waited;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got in_ready 0 expected 1 within 20 cycles");
      in_valid = 1'b0;
      return;
    end
    if (is_lo) exp_q.push_back('{cyc + 1, a, d});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends SYNC, n, then (for a legal n) words[0..n-1] and checksum xor cx; predicts outcome.
  task automatic frame(input int n, input logic [7:0] cx);
    logic [7:0] cs;
    send_byte(8'hA5, 1'b0, 5'd0, 16'h0);
    send_byte(n[7:0], 1'b0, 5'd0, 16'h0);
    if (n == 0 || n > Depth) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      exp_hold = 1'b1;
      return;
    end
    cs = n[7:0];
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8], 1'b0, 5'd0, 16'h0);
      send_byte(words[i][7:0], 1'b1, i[4:0], words[i]);
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
    end
    send_byte(cs ^ cx, 1'b0, 5'd0, 16'h0);
    exp_done = (cx == 8'h00);
    exp_err  = !exp_done;
    exp_hold = !exp_done;
  endtask

  task automatic check_flags(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err"}, 32'(load_err), 32'(exp_err));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned nr0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: good three-word frame, checksum 03^80^00^84^01^13^02 = 17.
    words[0] = 16'h8000;
    words[1] = 16'h8401;
    words[2] = 16'h1302;
    obs_addr.delete();
    obs_data.delete();
    frame(3, 8'h00);
    check_flags("t1");
    check("t1_writes", 32'(obs_addr.size()), 32'd3);
    if (obs_addr.size() == 3) begin
      check("t1_w0", {11'd0, obs_addr[0], obs_data[0]}, {11'd0, 5'd0, 16'h8000});
      check("t1_w1", {11'd0, obs_addr[1], obs_data[1]}, {11'd0, 5'd1, 16'h8401});
      check("t1_w2", {11'd0, obs_addr[2], obs_data[2]}, {11'd0, 5'd2, 16'h1302});
    end
    check("t1_done_lit", 32'(load_done), 32'd1);
    check("t1_hold_lit", 32'(cpu_hold), 32'd0);

    // Literal CSUM byte 17 must be accepted as correct.
    send_byte(8'hA5, 1'b0, 5'd0, 16'h0);
    send_byte(8'h03, 1'b0, 5'd0, 16'h0);
    send_byte(8'h80, 1'b0, 5'd0, 16'h0);
    send_byte(8'h00, 1'b1, 5'd0, 16'h8000);
    send_byte(8'h84, 1'b0, 5'd0, 16'h0);
    send_byte(8'h01, 1'b1, 5'd1, 16'h8401);
    send_byte(8'h13, 1'b0, 5'd0, 16'h0);
    send_byte(8'h02, 1'b1, 5'd2, 16'h1302);
    send_byte(8'h17, 1'b0, 5'd0, 16'h0);
    repeat (2) @(negedge clk);
    check("t1b_done_lit", 32'(load_done), 32'd1);

    // 2: same frame, bad checksum.
    frame(3, 8'h01);
    check_flags("t2");
    check("t2_err_lit", 32'(load_err), 32'd1);

    // 3: illegal lengths 00 and 21.
    frame(0, 8'h00);
    check_flags("t3a");
    frame(33, 8'h00);
    check_flags("t3b");

    // 4: garbage before a frame is discarded without touching the flags.
    send_byte(8'h00, 1'b0, 5'd0, 16'h0);
    send_byte(8'hFF, 1'b0, 5'd0, 16'h0);
    check_flags("t4_garbage");
    words[0] = 16'hA5A5;
    words[1] = 16'h12A5;
    frame(2, 8'h00);
    check_flags("t4");

    // 5: full-depth frame with random valid gaps.
    for (int i = 0; i < Depth; i++) words[i] = 16'($urandom);
    gaps = 1;
    nr0  = notready_cnt;
    frame(Depth, 8'h00);
    gaps = 0;
    check_flags("t5");
    check("t5_notready_cycles", notready_cnt - nr0, 32'd32);

    // 6: reset after the second HI byte.
    send_byte(8'hA5, 1'b0, 5'd0, 16'h0);
    send_byte(8'h03, 1'b0, 5'd0, 16'h0);
    send_byte(8'h80, 1'b0, 5'd0, 16'h0);
    send_byte(8'h00, 1'b1, 5'd0, 16'h8000);
    send_byte(8'h84, 1'b0, 5'd0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_reset");
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) words[i] = 16'h1111 * 16'(i + 1);
    frame(4, 8'h00);
    check_flags("t6");

    repeat (3) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
